// File: rtl/elevator_disp_pkg.sv
// ---------------------------------------------------------------------------
// elevator_disp_pkg
// Shared constants for the elevator display driver: controller state and
// floor codes, active-high seven-segment glyphs (gfedcba) and small helpers
// that map the controller codes onto glyphs.
// ---------------------------------------------------------------------------
package elevator_disp_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [6:0] glyph_t;

    // Controller state codes (code 3 is invalid)
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_UP   = 2'd1;
    localparam logic [1:0] ST_DOWN = 2'd2;

    // Controller floor codes (codes 0 and 3 are invalid)
    localparam logic [1:0] FL_1 = 2'd1;
    localparam logic [1:0] FL_2 = 2'd2;

    // Active-high glyphs, bit order gfedcba
    localparam glyph_t GLYPH_1     = 7'h06;
    localparam glyph_t GLYPH_2     = 7'h5B;
    localparam glyph_t GLYPH_U     = 7'h3E;
    localparam glyph_t GLYPH_D     = 7'h5E;
    localparam glyph_t GLYPH_DASH  = 7'h40;
    localparam glyph_t GLYPH_F     = 7'h71;
    localparam glyph_t GLYPH_O_UP  = 7'h3F;
    localparam glyph_t GLYPH_O_LO  = 7'h5C;
    localparam glyph_t GLYPH_N     = 7'h54;
    localparam glyph_t GLYPH_E     = 7'h79;
    localparam glyph_t GLYPH_BLANK = 7'h00;

    // Glyph for the controller state code; anything unknown reads as 'E'
    function automatic glyph_t state_glyph(input logic [1:0] code);
        glyph_t g;
        case (code)
            ST_IDLE: g = GLYPH_DASH;
            ST_UP:   g = GLYPH_U;
            ST_DOWN: g = GLYPH_D;
            default: g = GLYPH_E;
        endcase
        return g;
    endfunction

    // Glyph for the controller floor code; anything unknown reads as 'E'
    function automatic glyph_t floor_glyph(input logic [1:0] code);
        glyph_t g;
        case (code)
            FL_1:    g = GLYPH_1;
            FL_2:    g = GLYPH_2;
            default: g = GLYPH_E;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/elevator_disp_driver_scan.sv
// ---------------------------------------------------------------------------
// seven_seg_scan
// Time-multiplexes four active-high glyphs onto a common-anode display.
// Each digit stays selected for SCAN_TICKS clocks, index order 0,1,2,3.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_glyph0..3       active-high glyphs for digits 0 (right) .. 3 (left)
//   o_seg_n           registered active-low segments {dp,g,f,e,d,c,b,a}
//   o_an_n            registered active-low digit enables, one-hot low
// ---------------------------------------------------------------------------
module seven_seg_scan
    import elevator_disp_pkg::*;
#(
    parameter int SCAN_TICKS = 50_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] i_glyph0,
    input  logic [6:0] i_glyph1,
    input  logic [6:0] i_glyph2,
    input  logic [6:0] i_glyph3,
    output logic [7:0] o_seg_n,
    output logic [3:0] o_an_n
);

    localparam int                SCAN_W    = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_TICKS - 1);
    localparam logic [SCAN_W-1:0] SCAN_ONE  = SCAN_W'(1);

    logic [SCAN_W-1:0] r_scan_cnt;
    logic [1:0]        r_digit_idx;
    logic [6:0]        w_glyph;
    logic [3:0]        w_an_n;
    logic [7:0]        r_seg_n;
    logic [3:0]        r_an_n;

    // Scan counter and digit index; index advances on the terminal count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_cnt  <= {SCAN_W{1'b0}};
            r_digit_idx <= 2'd0;
        end else if (r_scan_cnt == SCAN_LAST) begin
            r_scan_cnt  <= {SCAN_W{1'b0}};
            r_digit_idx <= r_digit_idx + 2'd1;
        end else begin
            r_scan_cnt  <= r_scan_cnt + SCAN_ONE;
            r_digit_idx <= r_digit_idx;
        end
    end

    // Glyph and anode pattern for the currently selected digit
    always_comb begin
        w_glyph = GLYPH_BLANK;
        w_an_n  = 4'b1111;
        case (r_digit_idx)
            2'd0: begin w_glyph = i_glyph0; w_an_n = 4'b1110; end
            2'd1: begin w_glyph = i_glyph1; w_an_n = 4'b1101; end
            2'd2: begin w_glyph = i_glyph2; w_an_n = 4'b1011; end
            2'd3: begin w_glyph = i_glyph3; w_an_n = 4'b0111; end
            default: begin w_glyph = GLYPH_BLANK; w_an_n = 4'b1111; end
        endcase
    end

    // Output register; dp is never lit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg_n <= 8'hFF;
            r_an_n  <= 4'hF;
        end else begin
            r_seg_n <= {1'b1, ~w_glyph};
            r_an_n  <= w_an_n;
        end
    end

    assign o_seg_n = r_seg_n;
    assign o_an_n  = r_an_n;

endmodule

// File: rtl/elevator_disp_driver.sv
// ---------------------------------------------------------------------------
// elevator_disp_driver
// Display-side consumer of the elevator controller display interface.
// Picks one of three screens ("OFF", a timed "on" banner, or the
// state/floor readout with a blinking moving-state glyph) and hands the
// four glyphs to seven_seg_scan for multiplexed common-anode drive.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   disp_state_code[1:0]  0 IDLE, 1 UP, 2 DOWN, 3 invalid
//   disp_floor_code[1:0]  1 floor 1, 2 floor 2, 0/3 invalid
//   disp_show_on_pulse    one-cycle request to show "on"
//   disp_off_en           level, 1 shows "OFF" (highest priority)
//   seg_n[7:0]            active-low segments {dp,g,f,e,d,c,b,a}
//   an_n[3:0]             active-low digit enables, an_n[3] leftmost
// ---------------------------------------------------------------------------
module elevator_disp_driver
    import elevator_disp_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int SCAN_TICKS  = 50_000,
    parameter int ON_TICKS    = CLK_FREQ_HZ,
    parameter int BLINK_TICKS = CLK_FREQ_HZ / 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] disp_state_code,
    input  logic [1:0] disp_floor_code,
    input  logic       disp_show_on_pulse,
    input  logic       disp_off_en,
    output logic [7:0] seg_n,
    output logic [3:0] an_n
);

    localparam int                 ON_W       = $clog2(ON_TICKS + 1);
    localparam logic [ON_W-1:0]    ON_LOAD    = ON_W'(ON_TICKS);
    localparam logic [ON_W-1:0]    ON_ONE     = ON_W'(1);
    localparam int                 BLINK_W    = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);
    localparam logic [BLINK_W-1:0] BLINK_ONE  = BLINK_W'(1);

    logic [ON_W-1:0]    r_on_cnt;
    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_blink_phase;
    logic               w_banner;
    logic               w_moving;
    glyph_t             w_d0;
    glyph_t             w_d1;
    glyph_t             w_d2;
    glyph_t             w_d3;

    // On-banner hold timer: off clears (and swallows a pulse), pulse reloads,
    // otherwise count down and rest at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_on_cnt <= {ON_W{1'b0}};
        end else if (disp_off_en) begin
            r_on_cnt <= {ON_W{1'b0}};
        end else if (disp_show_on_pulse) begin
            r_on_cnt <= ON_LOAD;
        end else if (r_on_cnt != {ON_W{1'b0}}) begin
            r_on_cnt <= r_on_cnt - ON_ONE;
        end else begin
            r_on_cnt <= r_on_cnt;
        end
    end

    // Free-running blink timebase, independent of mode and state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_cnt   <= {BLINK_W{1'b0}};
            r_blink_phase <= 1'b0;
        end else if (r_blink_cnt == BLINK_LAST) begin
            r_blink_cnt   <= {BLINK_W{1'b0}};
            r_blink_phase <= ~r_blink_phase;
        end else begin
            r_blink_cnt   <= r_blink_cnt + BLINK_ONE;
            r_blink_phase <= r_blink_phase;
        end
    end

    assign w_banner = (r_on_cnt != {ON_W{1'b0}});
    assign w_moving = (disp_state_code == ST_UP) || (disp_state_code == ST_DOWN);

    // Screen selection, OFF > banner > normal readout
    always_comb begin
        w_d3 = GLYPH_BLANK;
        w_d2 = GLYPH_BLANK;
        w_d1 = GLYPH_BLANK;
        w_d0 = GLYPH_BLANK;
        if (disp_off_en) begin
            w_d3 = GLYPH_O_UP;
            w_d2 = GLYPH_F;
            w_d1 = GLYPH_F;
            w_d0 = GLYPH_BLANK;
        end else if (w_banner) begin
            w_d3 = GLYPH_O_LO;
            w_d2 = GLYPH_N;
            w_d1 = GLYPH_BLANK;
            w_d0 = GLYPH_BLANK;
        end else begin
            // Only the moving states blink; IDLE and invalid stay steady
            if (w_moving && r_blink_phase) begin
                w_d3 = GLYPH_BLANK;
            end else begin
                w_d3 = state_glyph(disp_state_code);
            end
            w_d2 = GLYPH_BLANK;
            w_d1 = GLYPH_F;
            w_d0 = floor_glyph(disp_floor_code);
        end
    end

    seven_seg_scan #(
        .SCAN_TICKS (SCAN_TICKS)
    ) u_scan (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_glyph0 (w_d0),
        .i_glyph1 (w_d1),
        .i_glyph2 (w_d2),
        .i_glyph3 (w_d3),
        .o_seg_n  (seg_n),
        .o_an_n   (an_n)
    );

endmodule
